// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths, source indices and entry type for the CDB writeback arbiter
package cdb_arbiter_pkg;

  localparam int CDB_TAG_W  = 5;
  localparam int CDB_DATA_W = 32;
  localparam int NSRC       = 3;

  localparam logic [1:0] SRC_ALU1 = 2'd0;
  localparam logic [1:0] SRC_ALU2 = 2'd1;
  localparam logic [1:0] SRC_LSU  = 2'd2;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] val;
  } cdb_entry_t;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == SRC_LSU) ? SRC_ALU1 : s + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer result inputs and the two CDB broadcast ports
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
);
  logic [NSRC-1:0]        src_valid;
  logic [NSRC*TAG_W-1:0]  src_tag;
  logic [NSRC*DATA_W-1:0] src_val;
  logic [NSRC-1:0]        src_ready;
  logic                   cdb0_valid;
  logic [TAG_W-1:0]       cdb0_tag;
  logic [DATA_W-1:0]      cdb0_val;
  logic                   cdb1_valid;
  logic [TAG_W-1:0]       cdb1_tag;
  logic [DATA_W-1:0]      cdb1_val;

  modport slave (
    input  src_valid, src_tag, src_val,
    output src_ready, cdb0_valid, cdb0_tag, cdb0_val, cdb1_valid, cdb1_tag, cdb1_val
  );

  modport master (
    output src_valid, src_tag, src_val,
    input  src_ready, cdb0_valid, cdb0_tag, cdb0_val, cdb1_valid, cdb1_tag, cdb1_val
  );
endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// rtl/cdb_arbiter_result_fifo.sv - per-producer result FIFO with flush, count and registered head
module cdb_arbiter_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH):0]       count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d  = push_i ? wr_q + PW'(1) : wr_q;
    rd_d  = pop_i  ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin writeback arbiter: three producer FIFOs onto two registered CDB ports
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int EW = TAG_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NSRC-1:0] ready, push, pop, nonempty;
  logic [EW-1:0]   head  [NSRC];
  logic [CW-1:0]   count [NSRC];

  // Ready looks only at the registered count, so a full FIFO cannot refill on its pop cycle.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign ready[i]    = count[i] < CW'(DEPTH);
    assign push[i]     = bus.src_valid[i] & ready[i];
    assign nonempty[i] = |count[i];

    cdb_arbiter_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .flush_i (flush),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .data_i  ({bus.src_tag[i*TAG_W +: TAG_W], bus.src_val[i*DATA_W +: DATA_W]}),
      .head_o  (head[i]),
      .count_o (count[i])
    );
  end

  assign bus.src_ready = ready;

  logic [1:0]    rr_q, rr_d, idx;
  logic [1:0]    g0_idx, g1_idx;
  logic          g0_v, g1_v;
  logic          c0v_q, c0v_d, c1v_q, c1v_d;
  logic [EW-1:0] c0_q, c0_d, c1_q, c1_d;

  always_comb begin
    pop    = '0;
    g0_v   = 1'b0;
    g1_v   = 1'b0;
    g0_idx = '0;
    g1_idx = '0;
    idx    = rr_q;
    for (int k = 0; k < NSRC; k++) begin
      if (nonempty[idx]) begin
        if (!g0_v) begin
          g0_v     = 1'b1;
          g0_idx   = idx;
          pop[idx] = 1'b1;
        end else if (!g1_v) begin
          g1_v     = 1'b1;
          g1_idx   = idx;
          pop[idx] = 1'b1;
        end
      end
      idx = next_src(idx);
    end

    rr_d = rr_q;
    if (g1_v) begin
      rr_d = next_src(g1_idx);
    end else if (g0_v) begin
      rr_d = next_src(g0_idx);
    end

    c0v_d = g0_v;
    c1v_d = g1_v;
    c0_d  = g0_v ? head[g0_idx] : '0;
    c1_d  = g1_v ? head[g1_idx] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q  <= '0;
      c0v_q <= 1'b0;
      c1v_q <= 1'b0;
      c0_q  <= '0;
      c1_q  <= '0;
    end else if (flush) begin
      rr_q  <= '0;
      c0v_q <= 1'b0;
      c1v_q <= 1'b0;
      c0_q  <= '0;
      c1_q  <= '0;
    end else begin
      rr_q  <= rr_d;
      c0v_q <= c0v_d;
      c1v_q <= c1v_d;
      c0_q  <= c0_d;
      c1_q  <= c1_d;
    end
  end

  assign bus.cdb0_valid = c0v_q;
  assign bus.cdb0_tag   = c0_q[EW-1 -: TAG_W];
  assign bus.cdb0_val   = c0_q[DATA_W-1:0];
  assign bus.cdb1_valid = c1v_q;
  assign bus.cdb1_tag   = c1_q[EW-1 -: TAG_W];
  assign bus.cdb1_val   = c1_q[DATA_W-1:0];

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter with queue-based reference model
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  cdb_arbiter_if bus ();

  cdb_arbiter #(
    .TAG_W  (CDB_TAG_W),
    .DATA_W (CDB_DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per producer, a round-robin start index, expected CDB word.
  cdb_entry_t   mq [NSRC][$];
  int           rr_m = 0;
  logic [75:0]  exp_out = '0;
  logic [2:0]   acc;
  logic         cur_fl;
  logic [2:0]   cur_v;
  cdb_entry_t   cur_e [NSRC];
  logic [2:0]   last_rdy_m, last_rdy_dut;

  typedef struct {
    logic        fl;
    logic [2:0]  v;
    logic [4:0]  t0, t1, t2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  rdy;
    logic [75:0] out;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [75:0] o(input logic c0v, input logic [4:0] c0t, input logic [31:0] c0d,
                                    input logic c1v, input logic [4:0] c1t, input logic [31:0] c1d);
    return {c0v, c0t, c0d, c1v, c1t, c1d};
  endfunction

  function automatic logic [75:0] act_out();
    return {bus.cdb0_valid, bus.cdb0_tag, bus.cdb0_val, bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_val};
  endfunction

  function automatic logic [2:0] model_rdy();
    logic [2:0] r;
    for (int s = 0; s < NSRC; s++) r[s] = mq[s].size() < DEPTH;
    return r;
  endfunction

  task automatic model_edge();
    int g [$];
    logic [2:0] rdy;
    int s;
    rdy = model_rdy();
    acc = '0;
    if (cur_fl) begin
      for (int i = 0; i < NSRC; i++) mq[i].delete();
      rr_m = 0;
      exp_out = '0;
      return;
    end
    for (int k = 0; k < NSRC; k++) begin
      s = (rr_m + k) % NSRC;
      if (mq[s].size() > 0 && g.size() < 2) g.push_back(s);
    end
    exp_out = '0;
    if (g.size() > 0) exp_out[75:38] = {1'b1, mq[g[0]][0]};
    if (g.size() > 1) exp_out[37:0]  = {1'b1, mq[g[1]][0]};
    foreach (g[i]) void'(mq[g[i]].pop_front());
    for (int i = 0; i < NSRC; i++) begin
      if (cur_v[i] && rdy[i]) begin
        mq[i].push_back(cur_e[i]);
        acc[i] = 1'b1;
      end
    end
    if (g.size() > 0) rr_m = (g[g.size()-1] + 1) % NSRC;
  endtask

  // Called at a falling edge: drive inputs, check ready, clock once, check the CDB ports.
  task automatic step(input logic fl, input logic [2:0] v, input logic [4:0] t0, t1, t2,
                      input logic [31:0] d0, d1, d2);
    cur_fl = fl;
    cur_v  = v;
    cur_e[0] = '{tag: t0, val: d0};
    cur_e[1] = '{tag: t1, val: d1};
    cur_e[2] = '{tag: t2, val: d2};
    flush = fl;
    bus.src_valid = v;
    bus.src_tag   = {t2, t1, t0};
    bus.src_val   = {d2, d1, d0};
    #1;
    last_rdy_m   = model_rdy();
    last_rdy_dut = bus.src_ready;
    check("src_ready", last_rdy_dut, last_rdy_m);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cdb_out", act_out(), exp_out);
    check("port0_first", bus.cdb1_valid & ~bus.cdb0_valid, 1'b0);
  endtask

  task automatic add(input logic fl, input logic [2:0] v, input logic [4:0] t0, t1, t2,
                     input logic [31:0] d0, d1, d2, input logic [2:0] rdy, input logic [75:0] out);
    vec_t r;
    r.fl = fl; r.v = v; r.t0 = t0; r.t1 = t1; r.t2 = t2;
    r.d0 = d0; r.d1 = d1; r.d2 = d2; r.rdy = rdy; r.out = out;
    tbl.push_back(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  int lsu_i, blocked, seen_bad;
  int gcnt [NSRC];
  logic [4:0] lsu_seen [$];
  logic [2:0] vb;

  initial begin
    bus.src_valid = '0;
    bus.src_tag   = '0;
    bus.src_val   = '0;
    #2;
    check("reset_out", act_out(), 76'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) add(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, '0);
    add(0, 3'b001, 5, 0, 0, 32'hAA, 0, 0, 3'b111, '0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, o(1, 5, 32'hAA, 0, 0, 0));
    add(0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b111, '0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, o(1, 2, 32'h22, 1, 3, 32'h33));
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, o(1, 1, 32'h11, 0, 0, 0));
    add(0, 3'b010, 0, 6, 0, 0, 32'h66, 0, 3'b111, '0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, o(1, 6, 32'h66, 0, 0, 0));
    add(0, 3'b100, 0, 0, 4, 0, 0, 32'h44, 3'b111, '0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, o(1, 4, 32'h44, 0, 0, 0));
    add(0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b111, '0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, o(1, 1, 32'h11, 1, 2, 32'h22));
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, o(1, 3, 32'h33, 0, 0, 0));
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, '0);

    foreach (tbl[i]) begin
      step(tbl[i].fl, tbl[i].v, tbl[i].t0, tbl[i].t1, tbl[i].t2, tbl[i].d0, tbl[i].d1, tbl[i].d2);
      check("vec_ready", last_rdy_dut, tbl[i].rdy);
      check("vec_out", act_out(), tbl[i].out);
    end

    // Back-pressure on the LSU while both ALUs stay busy.
    step(1'b1, 3'b000, 0, 0, 0, 0, 0, 0);
    lsu_i = 0;
    blocked = 0;
    for (int c = 0; c < 20; c++) begin
      vb = {(lsu_i < 3) ? 1'b1 : 1'b0, 2'b11};
      step(1'b0, vb, 5'(16 + c % 4), 5'(20 + c % 4), 5'(7 + lsu_i), 32'(c), 32'(c + 100), 32'(lsu_i + 7));
      if (vb[2] && lsu_i == 2 && !last_rdy_dut[2]) blocked = 1;
      if (acc[2]) lsu_i++;
      if (bus.cdb0_valid && bus.cdb0_tag >= 7 && bus.cdb0_tag <= 9) lsu_seen.push_back(bus.cdb0_tag);
      if (bus.cdb1_valid && bus.cdb1_tag >= 7 && bus.cdb1_tag <= 9) lsu_seen.push_back(bus.cdb1_tag);
    end
    for (int c = 0; c < 4; c++) begin
      idle(1);
      if (bus.cdb0_valid && bus.cdb0_tag >= 7 && bus.cdb0_tag <= 9) lsu_seen.push_back(bus.cdb0_tag);
      if (bus.cdb1_valid && bus.cdb1_tag >= 7 && bus.cdb1_tag <= 9) lsu_seen.push_back(bus.cdb1_tag);
    end
    check("lsu_blocked_when_full", blocked, 1);
    check("lsu_count", lsu_seen.size(), 3);
    if (lsu_seen.size() == 3) check("lsu_order", {lsu_seen[0], lsu_seen[1], lsu_seen[2]}, {5'd7, 5'd8, 5'd9});

    // Saturation fairness: 30 full-throughput cycles after the fill cycle.
    step(1'b1, 3'b000, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < NSRC; s++) gcnt[s] = 0;
    for (int c = 0; c < 32; c++) begin
      step(1'b0, 3'b111, {2'd0, 3'(c)}, {2'd1, 3'(c)}, {2'd2, 3'(c)}, 32'(c), 32'(c), 32'(c));
      if (c >= 1 && c <= 30) begin
        if (bus.cdb0_valid) gcnt[bus.cdb0_tag[4:3]]++;
        if (bus.cdb1_valid) gcnt[bus.cdb1_tag[4:3]]++;
      end
    end
    for (int s = 0; s < NSRC; s++) check("fairness", (gcnt[s] >= 19 && gcnt[s] <= 21), 1'b1);
    idle(4);

    // Flush with data in flight and a concurrent ALU2 push.
    for (int c = 0; c < 3; c++) step(1'b0, 3'b111, 5'(c), 5'(c + 8), 5'(c + 16), 32'(c), 32'(c), 32'(c));
    step(1'b1, 3'b010, 0, 5'd31, 0, 0, 32'hDEADBEEF, 0);
    check("flush_valids", {bus.cdb0_valid, bus.cdb1_valid}, 2'b00);
    check("flush_ready", bus.src_ready, 3'b111);
    seen_bad = 0;
    for (int c = 0; c < 4; c++) begin
      idle(1);
      if ((bus.cdb0_valid && bus.cdb0_val == 32'hDEADBEEF) || (bus.cdb1_valid && bus.cdb1_val == 32'hDEADBEEF))
        seen_bad = 1;
    end
    check("flush_drops_push", seen_bad, 0);

    // Randomized traffic against the model, with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 31) == 0), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           $urandom, $urandom, $urandom);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
